// File: rtl/fp2dec_pkg.sv
// Shared types and constants for the float-to-decimal converter.
// The FP2DEC_ROUND_EN macro adds the ROUND state used for guard-digit rounding.
package fp2dec_pkg;

  localparam int INT_DIGITS = 9;
  localparam int INT_BITS   = 27;
  localparam int FRAC_BITS  = 32;
  localparam int BIAS       = 127;
  localparam int MAN_BITS   = 23;

  // Largest biased exponent whose integer part still fits in INT_BITS
  localparam logic [7:0] MAX_EXP = 8'(BIAS + INT_BITS - 1);

  typedef enum logic [2:0] {
    CLS_NUM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_RANGE
  } cls_t;

`ifdef FP2DEC_ROUND_EN
  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    CONV_INT,
    CONV_FRAC,
    ROUND,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    CONV_INT,
    CONV_FRAC,
    DONE
  } state_t;
`endif

  // Denormals are flushed to zero rather than converted
  function automatic cls_t classify(input logic [7:0] exp_b, input logic [22:0] man);
    cls_t c;
    if (exp_b == 8'hFF)
      c = (man == '0) ? CLS_INF : CLS_NAN;
    else if (exp_b == 8'h00)
      c = CLS_ZERO;
    else if (exp_b > MAX_EXP)
      c = CLS_RANGE;
    else
      c = CLS_NUM;
    return c;
  endfunction

endpackage

// File: rtl/fp2dec_step.sv
// One double-dabble step over the nine integer BCD digits:
// add 3 to every digit >= 5, then shift left pulling in the next binary bit.
module bcd_add3_shift
  import fp2dec_pkg::*;
(
  input  logic [4*INT_DIGITS-1:0] bcd_in,
  input  logic                    bit_in,
  output logic [4*INT_DIGITS-1:0] bcd_out
);

  logic [4*INT_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
    end
    bcd_out = (adj << 1) | {{(4*INT_DIGITS-1){1'b0}}, bit_in};
  end

endmodule

// File: rtl/fp2dec.sv
// Converts an IEEE754 single into sign, 9 integer BCD digits and FRAC_DIGITS fraction digits.
// Define FP2DEC_ROUND_EN to round on a guard digit instead of truncating.
module fp2dec
  import fp2dec_pkg::*;
#(
  parameter int FRAC_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              fp_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign,
  output logic [4*INT_DIGITS-1:0]  int_bcd,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd,
  output cls_t                     cls
);

  localparam int BW = 4*INT_DIGITS;
  localparam int FW = 4*FRAC_DIGITS;
  localparam int SW = INT_BITS + FRAC_BITS;

  localparam logic [5:0] INT_LAST  = 6'(INT_BITS - 1);
`ifdef FP2DEC_ROUND_EN
  localparam logic [5:0] FRAC_LAST = 6'(FRAC_DIGITS);
`else
  localparam logic [5:0] FRAC_LAST = 6'(FRAC_DIGITS - 1);
`endif

  state_t               state;
  logic [31:0]          fp_q;
  logic [INT_BITS-1:0]  int_bin;
  logic [FRAC_BITS-1:0] frac_q;
  logic [5:0]           cnt;

  cls_t                 cls_c;
  logic signed [9:0]    unb;
  logic signed [9:0]    sh;
  logic [9:0]           lsh;
  logic [9:0]           rsh;
  logic [SW-1:0]        base;
  logic [SW-1:0]        scaled;
  logic [35:0]          prod;
  logic [3:0]           digit;
  logic [FW-1:0]        digit_ext;
  logic [BW-1:0]        dd_out;

  // Place {1,man} so the binary point sits between bit FRAC_BITS and FRAC_BITS-1
  always_comb begin
    cls_c  = classify(fp_q[30:23], fp_q[22:0]);
    unb    = $signed({2'b00, fp_q[30:23]}) - $signed(10'(BIAS));
    sh     = unb + $signed(10'(FRAC_BITS - MAN_BITS));
    lsh    = 10'(sh);
    rsh    = 10'(-sh);
    base   = SW'({1'b1, fp_q[22:0]});
    scaled = (sh >= 0) ? (base << lsh) : (base >> rsh);
  end

  always_comb begin
    prod      = ({4'd0, frac_q} << 3) + ({4'd0, frac_q} << 1);
    digit     = prod[35:32];
    digit_ext = '0;
    digit_ext[3:0] = digit;
  end

  bcd_add3_shift u_step (
    .bcd_in  (int_bcd),
    .bit_in  (int_bin[INT_BITS-1]),
    .bcd_out (dd_out)
  );

`ifdef FP2DEC_ROUND_EN
  logic [3:0]       guard;
  logic [BW+FW-1:0] all_q;
  logic [BW+FW-1:0] all_inc;
  logic             carry;

  // Increment the whole decimal string by one ulp; an all-nines string stays put
  always_comb begin
    all_q   = {int_bcd, frac_bcd};
    all_inc = all_q;
    carry   = 1'b1;
    for (int i = 0; i < INT_DIGITS + FRAC_DIGITS; i++) begin
      if (carry) begin
        if (all_q[4*i +: 4] == 4'd9) begin
          all_inc[4*i +: 4] = 4'd0;
        end else begin
          all_inc[4*i +: 4] = all_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry)
      all_inc = all_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      int_bcd   <= '0;
      frac_bcd  <= '0;
      cls       <= CLS_ZERO;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            fp_q     <= fp_in;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end else begin
            in_ready <= 1'b1;
          end
        end
        UNPACK: begin
          sign     <= fp_q[31];
          cls      <= cls_c;
          int_bcd  <= '0;
          frac_bcd <= '0;
          cnt      <= '0;
          int_bin  <= scaled[SW-1:FRAC_BITS];
          frac_q   <= scaled[FRAC_BITS-1:0];
          if (cls_c == CLS_NUM) begin
            state <= CONV_INT;
          end else begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        CONV_INT: begin
          int_bcd <= dd_out;
          int_bin <= int_bin << 1;
          if (cnt == INT_LAST) begin
            cnt   <= '0;
            state <= CONV_FRAC;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        CONV_FRAC: begin
          frac_q <= prod[FRAC_BITS-1:0];
          cnt    <= cnt + 6'd1;
`ifdef FP2DEC_ROUND_EN
          if (cnt == FRAC_LAST) begin
            guard <= digit;
            state <= ROUND;
          end else begin
            frac_bcd <= (frac_bcd << 4) | digit_ext;
          end
`else
          frac_bcd <= (frac_bcd << 4) | digit_ext;
          if (cnt == FRAC_LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
`endif
        end
`ifdef FP2DEC_ROUND_EN
        ROUND: begin
          if (guard >= 4'd5)
            {int_bcd, frac_bcd} <= all_inc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp2dec.sv
// Self-checking bench for fp2dec: exact-integer reference model, per-cycle output compare,
// directed corner cases plus randomized operands.
module tb_fp2dec;
  import fp2dec_pkg::*;

  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     fp_in;
  logic            out_valid;
  logic            out_ready;
  logic            sign;
  logic [35:0]     int_bcd;
  logic [4*FD-1:0] frac_bcd;
  cls_t            cls;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    cls_t            c;
    logic            s;
    logic [35:0]     ib;
    logic [4*FD-1:0] fb;
    int              lat;
    int              acc;
  } exp_t;

  exp_t q[$];
  bit   seen = 1'b0;
  exp_t mon_e;

  fp2dec #(.FRAC_DIGITS(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .int_bcd   (int_bcd),
    .frac_bcd  (frac_bcd),
    .cls       (cls)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic longint unsigned to_bcd(input longint unsigned v, input int nd);
    longint unsigned r = 0;
    for (int i = 0; i < nd; i++) begin
      r = r | ((v % 10) << (4*i));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // value = mf * 2^(ue-23); take the integer part and the fraction truncated to 32 bits,
  // then read decimal digits as floor(fraction * 10^k)
  function automatic exp_t model(input logic [31:0] fp);
    exp_t r;
    int ue, sh23;
    longint unsigned mf, ip, rem, fr, d, g, tot;
    r.s = fp[31]; r.ib = '0; r.fb = '0; r.lat = 1; r.acc = 0;
    ue = int'(fp[30:23]) - 127;
    if (fp[30:23] == 8'hFF)      r.c = (fp[22:0] == 0) ? CLS_INF : CLS_NAN;
    else if (fp[30:23] == 8'h00) r.c = CLS_ZERO;
    else if (ue > 26)            r.c = CLS_RANGE;
    else begin
      r.c = CLS_NUM;
      mf  = 64'(fp[22:0]) + 64'h800000;
      if (ue >= 23) begin
        ip = mf << (ue - 23);
        fr = 0;
      end else begin
        sh23 = 23 - ue;
        ip   = (sh23 >= 64) ? 0 : (mf >> sh23);
        rem  = (sh23 >= 64) ? mf : (mf - (ip << sh23));
        if (sh23 <= 32)           fr = rem << (32 - sh23);
        else if (sh23 - 32 >= 64) fr = 0;
        else                      fr = rem >> (sh23 - 32);
      end
      d = (fr * pow10(FD)) >> 32;
`ifdef FP2DEC_ROUND_EN
      g = ((fr * pow10(FD + 1)) >> 32) % 10;
      if (g >= 5) begin
        tot = ip * pow10(FD) + d + 1;
        if (tot >= pow10(9 + FD)) tot = pow10(9 + FD) - 1;
        ip = tot / pow10(FD);
        d  = tot % pow10(FD);
      end
      r.lat = 30 + FD;
`else
      g = 0;
      r.lat = 28 + FD;
`endif
      r.ib = 36'(to_bcd(ip, 9));
      r.fb = (4*FD)'(to_bcd(d, FD));
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    case ($urandom_range(0, 9))
      0:       ex = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      1:       ex = 8'($urandom_range(154, 254));
      default: ex = 8'($urandom_range(100, 153));
    endcase
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  // Compare process: every cycle the result is valid it must match the model
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("sign", 64'(sign), 64'(q[0].s));
          check("cls", 64'(cls), 64'(q[0].c));
          check("int_bcd", 64'(int_bcd), 64'(q[0].ib));
          check("frac_bcd", 64'(frac_bcd), 64'(q[0].fb));
          check("in_ready_in_done", 64'(in_ready), 64'd0);
          if (!seen) begin
            check("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_e     = model(fp_in);
        mon_e.acc = cyc + 1;
        q.push_back(mon_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand, then wait until the result is presented (left un-acknowledged)
  task automatic applyStimulus(input logic [31:0] fp, input bit noise);
    int budget = 0;
    while (!in_ready && budget < 200) begin step(); budget++; end
    if (!in_ready) begin
      check("timeout_in_ready", 64'd0, 64'd1);
      return;
    end
    in_valid = 1'b1;
    fp_in    = fp;
    step();
    in_valid = 1'b0;
    fp_in    = $urandom;
    budget   = 0;
    while (!out_valid && budget < 200) begin
      if (noise) begin
        in_valid = 1'($urandom);
        fp_in    = $urandom;
      end
      step();
      budget++;
    end
    in_valid = 1'b0;
    if (!out_valid) check("timeout_out_valid", 64'd0, 64'd1);
  endtask

  task automatic releaseOutput();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic s, input logic [35:0] ib,
                             input logic [4*FD-1:0] fb, input cls_t c);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_sign"}, 64'(sign), 64'(s));
    check({name, "_int"}, 64'(int_bcd), 64'(ib));
    check({name, "_frac"}, 64'(frac_bcd), 64'(fb));
    check({name, "_cls"}, 64'(cls), 64'(c));
  endtask

  logic [31:0] specials [5] = '{32'h00000000, 32'h00400000, 32'h7F800000, 32'hFF800001, 32'h4F000000};
  cls_t        spec_cls [5] = '{CLS_ZERO, CLS_ZERO, CLS_INF, CLS_NAN, CLS_RANGE};

  initial begin
    exp_t e;
    bit   stray;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fp_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sign", 64'(sign), 64'd0);
    check("rst_int", 64'(int_bcd), 64'd0);
    check("rst_frac", 64'(frac_bcd), 64'd0);
    check("rst_cls", 64'(cls), 64'(CLS_ZERO));
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Pin the reference model to hand-computed values
    e = model(32'h3FC00000);
    check("model_1p5_int", 64'(e.ib), 64'h1);
    check("model_1p5_frac", 64'(e.fb), 64'h5000);
    check("model_1p5_cls", 64'(e.c), 64'(CLS_NUM));
`ifdef FP2DEC_ROUND_EN
    check("model_1p5_lat", 64'(e.lat), 64'd34);
`else
    check("model_1p5_lat", 64'(e.lat), 64'd32);
`endif
    e = model(32'h4128A3D7);
    check("model_10p54_int", 64'(e.ib), 64'h10);
`ifdef FP2DEC_ROUND_EN
    check("model_10p54_frac", 64'(e.fb), 64'h5400);
`else
    check("model_10p54_frac", 64'(e.fb), 64'h5399);
`endif
    e = model(32'hC4FC74CD);
    check("model_2019_sign", 64'(e.s), 64'd1);
    check("model_2019_int", 64'(e.ib), 64'h2019);
    check("model_2019_frac", 64'(e.fb), 64'h6500);

    applyStimulus(32'h3FC00000, 1'b0);
    checkOutput("dut_1p5", 1'b0, 36'h1, 16'h5000, CLS_NUM);
    releaseOutput();

    applyStimulus(32'h4128A3D7, 1'b0);
`ifdef FP2DEC_ROUND_EN
    checkOutput("dut_10p54", 1'b0, 36'h10, 16'h5400, CLS_NUM);
`else
    checkOutput("dut_10p54", 1'b0, 36'h10, 16'h5399, CLS_NUM);
`endif
    releaseOutput();

    applyStimulus(32'hC4FC74CD, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("dut_2019_stall", 1'b1, 36'h2019, 16'h6500, CLS_NUM);
      step();
    end
    releaseOutput();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(specials[i], 1'b0);
      checkOutput("dut_special", specials[i][31], 36'h0, 16'h0, spec_cls[i]);
      releaseOutput();
    end

    // Reset while a result is being presented
    applyStimulus(32'h7F800000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_in_done_out_valid", 64'(out_valid), 64'd0);

    // Reset 10 cycles into the integer conversion drops the operand
    while (!in_ready) step();
    in_valid = 1'b1;
    fp_in    = 32'h40490FDB;
    step();
    in_valid = 1'b0;
    repeat (11) step();
    rst = 1'b1;
    step();
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    step();
    check("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
    stray = 1'b0;
    repeat (45) begin
      step();
      if (out_valid) stray = 1'b1;
    end
    check("rst_mid_no_result", 64'(stray), 64'd0);
    applyStimulus(32'hC0600000, 1'b0);
    checkOutput("dut_m3p5", 1'b1, 36'h3, 16'h5000, CLS_NUM);
    releaseOutput();

    // in_valid held high while the result waits for the consumer
    applyStimulus(32'h3FC00000, 1'b0);
    in_valid = 1'b1;
    fp_in    = 32'h40490FDB;
    repeat (3) begin
      step();
      check("no_accept_in_done", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ready_after_handshake", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("accepted_after_handshake", 64'(in_ready), 64'd0);
    begin
      int budget = 0;
      while (!out_valid && budget < 200) begin step(); budget++; end
      if (!out_valid) check("timeout_out_valid", 64'd0, 64'd1);
    end
    releaseOutput();

    for (int n = 0; n < 150; n++) begin
      applyStimulus(rand_fp(), 1'($urandom));
      repeat ($urandom_range(0, 3)) step();
      releaseOutput();
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp2dec.md
FP2DEC -- requirements
Module: fp2dec

Interface
- REQ-001 SHALL have parameter FRAC_DIGITS, default 4, fractional decimal digits produced (legal 1..8).
- REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
- REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-004 SHALL have port in_valid, input, 1, fp_in valid.
- REQ-005 SHALL have port in_ready, output, 1, block can accept.
- REQ-006 SHALL have port fp_in, input, 32, IEEE754 single, e.g. divider result.
- REQ-007 SHALL have port out_valid, output, 1, result fields valid.
- REQ-008 SHALL have port out_ready, input, 1, consumer accepts.
- REQ-009 SHALL have port sign, output, 1, sign of fp_in.
- REQ-010 SHALL have port int_bcd, output, 36, 9 BCD digits of the integer part, MSD first.
- REQ-011 SHALL have port frac_bcd, output, 4*FRAC_DIGITS, fractional BCD digits, MSD first.
- REQ-012 SHALL have port cls, output, 3, result class (fp2dec_pkg::cls_t).

Function
- REQ-013 SHALL use FSM states IDLE, UNPACK, CONV_INT, CONV_FRAC, ROUND (macro only), DONE.
- REQ-014 SHALL assert in_ready only in IDLE; transfer = in_valid&&in_ready; fp_in latched on that edge; next state UNPACK.
- REQ-015 SHALL classify in UNPACK: exp=255,man=0 -> CLS_INF; exp=255,man!=0 -> CLS_NAN; exp=0 (incl. denormals, flushed) -> CLS_ZERO; unbiased exp>26 -> CLS_RANGE; else CLS_NUM.
- REQ-016 SHALL go from UNPACK directly to DONE for any non-NUM class, with int_bcd=0 and frac_bcd=0; sign always reflects fp_in[31].
- REQ-017 SHALL, for CLS_NUM, split {1,man} at the binary point into a 27-bit integer and a 32-bit fraction; fraction bits below 2^-32 are discarded.
- REQ-018 SHALL run CONV_INT for exactly 27 cycles, one double-dabble (add-3, shift) step per cycle.
- REQ-019 SHALL run CONV_FRAC for exactly FRAC_DIGITS cycles; each cycle, frac*10 -> bits[35:32] form the next digit, bits[31:0] the new fraction.
- REQ-020 SHALL, without the macro, have latency of exactly 28+FRAC_DIGITS edges from the accept edge to out_valid high for CLS_NUM, and 1 edge for other classes.
- REQ-021 SHALL hold out_valid and all result outputs stable in DONE until out_valid&&out_ready; the next state is then IDLE.
- REQ-022 SHALL ignore in_valid outside IDLE; no input queueing.
- REQ-023 SHALL keep every output registered; no combinational path from input to output.

Reset
- REQ-024 SHALL, on rst, enter IDLE regardless of state, including mid-conversion or with out_valid high; the in-flight operand is dropped.
- REQ-025 SHALL hold reset values: in_ready=0 during rst, 1 on the first edge after release; out_valid=0, sign=0, int_bcd=0, frac_bcd=0, cls=CLS_ZERO.

Configuration
- REQ-026 SHALL honour macro FP2DEC_ROUND_EN; when defined, CONV_FRAC runs FRAC_DIGITS+1 cycles (guard digit) then 1 ROUND cycle: guard>=5 adds 1 ulp to frac_bcd with BCD carry rippling into int_bcd; latency becomes 30+FRAC_DIGITS.
- REQ-027 SHALL, when 999999999.9..9 would round up, saturate all digits at 9.
- REQ-028 SHALL, without FP2DEC_ROUND_EN, truncate, and no ROUND state or guard logic SHALL exist.

Structure
- REQ-029 SHALL place cls_t (CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN, CLS_RANGE), state enum, INT_DIGITS=9, INT_BITS=27, FRAC_BITS=32 and BIAS=127 in package fp2dec_pkg.
- REQ-030 SHALL instantiate one sub-module, bcd_add3_shift: combinational single double-dabble step over 9 digits, used in CONV_INT.

Verification
- REQ-031 SHALL cover 0x3FC00000 (1.5) -> sign 0, int_bcd 000000001, frac_bcd 5000, CLS_NUM; out_valid exactly 32 edges after accept (no macro).
- REQ-032 SHALL cover 0x4128A3D7 (10.54) -> int 000000010, frac 5399 without macro, 5400 with FP2DEC_ROUND_EN.
- REQ-033 SHALL cover 0xC4FC74CD (-2019.65) -> sign 1, int 000002019, frac 6500; out_ready held low 5 cycles, outputs stable throughout.
- REQ-034 SHALL cover 0x00000000, 0x00400000, 0x7F800000, 0xFF800001 and 0x4F000000 -> CLS_ZERO, CLS_ZERO, CLS_INF, CLS_NAN and CLS_RANGE respectively, each with out_valid 1 edge after accept and zero digits.
- REQ-035 SHALL cover rst asserted 10 cycles into CONV_INT -> IDLE, out_valid 0; a following 0xC0600000 (-3.5) converts to sign 1, int 3, frac 5000.
- REQ-036 SHALL cover in_valid held high in DONE -> no second accept until the out handshake; then accept on a subsequent cycle.
